// File: rtl/debug_uart_reporter_if.sv
// Bundle of the capture controls and UART/status outputs of debug_uart_reporter.
// The master side drives the controls; the slave side is the reporter itself.
interface debug_uart_reporter_if #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 16
) ();
  localparam int CountWidth = $clog2(FIFO_DEPTH) + 1;

  logic                  enable;
  logic [DATA_WIDTH-1:0] debug_in;
  logic                  clr_overflow;
  logic                  tx;
  logic                  busy;
  logic                  overflow;
  logic [CountWidth-1:0] fifo_count;

  modport master (
    output enable, debug_in, clr_overflow,
    input  tx, busy, overflow, fifo_count
  );

  modport slave (
    input  enable, debug_in, clr_overflow,
    output tx, busy, overflow, fifo_count
  );
endinterface

// File: rtl/debug_uart_reporter.sv
// Watches the core's debug word, queues every change and streams each queued
// word off-chip as an 8N1 UART frame A5, word[15:8], word[7:0].
module debug_uart_reporter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8,
  parameter int DATA_WIDTH   = 16
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  debug_uart_reporter_if.slave bus
);
  localparam int PtrWidth   = $clog2(FIFO_DEPTH);
  localparam int CountWidth = PtrWidth + 1;
  localparam int BaudWidth  = $clog2(CLKS_PER_BIT);
  localparam logic [BaudWidth-1:0]  BaudLast  = BaudWidth'(CLKS_PER_BIT - 1);
  localparam logic [CountWidth-1:0] CountFull = CountWidth'(FIFO_DEPTH);
  localparam logic [7:0]            SyncByte  = 8'hA5;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} txState_e;

  logic [1:0]            rstSync_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrWidth-1:0]   wrPtr_q, rdPtr_q;
  logic [CountWidth-1:0] count_q;
  logic                  overflow_q;

  txState_e              state_q, state_d;
  logic [BaudWidth-1:0]  baud_q, baud_d;
  logic [2:0]            bitIdx_q, bitIdx_d;
  logic [1:0]            byteIdx_q, byteIdx_d;
  logic [7:0]            shift_q, shift_d;
  logic [DATA_WIDTH-1:0] frame_q, frame_d;
  logic                  tx_q, tx_d;

  logic changeSeen, pop, full, pushOk, dropped, baudDone;

  // Stage 0 of the release chain gates capture; stage 1 gates the transmitter.
  assign changeSeen = bus.enable & rstSync_q[0] & (bus.debug_in != prev_q);
  assign pop        = (state_q == StIdle) & (count_q != '0) & rstSync_q[1];
  assign full       = (count_q == CountFull);
  assign pushOk     = changeSeen & (~full | pop);
  assign dropped    = changeSeen & full & ~pop;
  assign baudDone   = (baud_q == BaudLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rstSync_q  <= '0;
      prev_q     <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
      if (changeSeen) prev_q <= bus.debug_in;
      if (pushOk) wrPtr_q <= wrPtr_q + PtrWidth'(1);
      if (pop) rdPtr_q <= rdPtr_q + PtrWidth'(1);
      count_q <= count_q + CountWidth'(pushOk) - CountWidth'(pop);
      if (dropped) overflow_q <= 1'b1;
      else if (bus.clr_overflow) overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (pushOk) mem_q[wrPtr_q] <= bus.debug_in;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bitIdx_q  <= '0;
      byteIdx_q <= '0;
      shift_q   <= '0;
      frame_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bitIdx_q  <= bitIdx_d;
      byteIdx_q <= byteIdx_d;
      shift_q   <= shift_d;
      frame_q   <= frame_d;
      tx_q      <= tx_d;
    end
  end

  // tx_d is the line level for the state being entered, keeping tx registered.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + BaudWidth'(1);
    bitIdx_d  = bitIdx_q;
    byteIdx_d = byteIdx_q;
    shift_d   = shift_q;
    frame_d   = frame_q;
    tx_d      = tx_q;
    case (state_q)
      StIdle: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (pop) begin
          frame_d   = mem_q[rdPtr_q];
          byteIdx_d = '0;
          shift_d   = SyncByte;
          tx_d      = 1'b0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (baudDone) begin
          baud_d   = '0;
          bitIdx_d = '0;
          tx_d     = shift_q[0];
          state_d  = StData;
        end
      end
      StData: begin
        if (baudDone) begin
          baud_d = '0;
          if (bitIdx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
            shift_d  = shift_q >> 1;
            tx_d     = shift_q[1];
          end
        end
      end
      StStop: begin
        if (baudDone) begin
          baud_d = '0;
          if (byteIdx_q < 2'd2) begin
            byteIdx_d = byteIdx_q + 2'd1;
            shift_d   = (byteIdx_q == 2'd0) ? frame_q[15:8] : frame_q[7:0];
            tx_d      = 1'b0;
            state_d   = StStart;
          end else begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: begin
        baud_d  = '0;
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = (state_q != StIdle) | (count_q != '0);
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_debug_uart_reporter.sv
// Bench for debug_uart_reporter: directed scenarios plus random activity, every
// cycle compared against a queue-based model of the capture path and frame timing.
module tb_debug_uart_reporter;
  localparam int Cpb   = 4;
  localparam int Depth = 4;
  localparam int Frame = 30 * Cpb;

  logic clk  = 1'b0;
  logic rstN = 1'b1;

  debug_uart_reporter_if #(.FIFO_DEPTH(Depth), .DATA_WIDTH(16)) bus ();

  debug_uart_reporter #(
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (Depth),
    .DATA_WIDTH  (16)
  ) dut (
    .clk_i (clk),
    .rst_ni(rstN),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: queued words, remaining frame cycles, word on the line.
  logic [15:0] mPrev;
  logic [15:0] mQueue[$];
  int          mTxLeft;
  logic [15:0] mWord;
  bit          mOvf;
  int          sinceRelease;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic expTx();
    int k, slot, pos;
    logic [7:0] b;
    if (mTxLeft == 0) return 1'b1;
    k    = Frame - mTxLeft;
    slot = k / Cpb;
    pos  = slot % 10;
    case (slot / 10)
      0:       b = 8'hA5;
      1:       b = mWord[15:8];
      default: b = mWord[7:0];
    endcase
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  task automatic modelEdge(input bit en, input logic [15:0] d, input bit clr);
    bit popNow, dropped;
    if (!rstN) return;
    popNow = (mTxLeft == 0) && (mQueue.size() > 0) && (sinceRelease >= 2);
    if (mTxLeft > 0) mTxLeft--;
    if (popNow) begin
      mWord   = mQueue.pop_front();
      mTxLeft = Frame;
    end
    dropped = 1'b0;
    if (en && sinceRelease >= 1 && d != mPrev) begin
      mPrev = d;
      if (mQueue.size() < Depth) mQueue.push_back(d);
      else dropped = 1'b1;
    end
    if (clr) mOvf = 1'b0;
    if (dropped) mOvf = 1'b1;
    if (sinceRelease < 100) sinceRelease++;
  endtask

  task automatic checkAll();
    checkOutput("tx", bus.tx, expTx());
    checkOutput("fifo_count", bus.fifo_count, mQueue.size());
    checkOutput("busy", bus.busy, (mTxLeft > 0) || (mQueue.size() > 0));
    checkOutput("overflow", bus.overflow, mOvf);
  endtask

  // Called at a falling edge: drive, take one rising edge, check at the next falling edge.
  task automatic applyStimulus(input bit en, input logic [15:0] d, input bit clr);
    bus.enable       = en;
    bus.debug_in     = d;
    bus.clr_overflow = clr;
    @(posedge clk);
    modelEdge(en, d, clr);
    @(negedge clk);
    checkAll();
  endtask

  task automatic holdCycles(input int n);
    repeat (n) applyStimulus(bus.enable, bus.debug_in, 1'b0);
  endtask

  task automatic applyReset();
    rstN = 1'b0;
    mQueue.delete();
    mPrev        = '0;
    mTxLeft      = 0;
    mOvf         = 1'b0;
    sinceRelease = 0;
    #1;
    checkOutput("resetTx", bus.tx, 1'b1);
    checkOutput("resetCount", bus.fifo_count, 0);
    checkOutput("resetBusy", bus.busy, 1'b0);
    checkOutput("resetOverflow", bus.overflow, 1'b0);
    @(negedge clk);
    repeat (2) applyStimulus(bus.enable, bus.debug_in, 1'b0);
    rstN = 1'b1;
  endtask

  initial begin
    bus.enable       = 1'b1;
    bus.debug_in     = 16'h0000;
    bus.clr_overflow = 1'b0;
    mQueue.delete();
    mPrev        = '0;
    mTxLeft      = 0;
    mWord        = '0;
    mOvf         = 1'b0;
    sinceRelease = 0;
    @(negedge clk);
    applyReset();

    // Single change and its frame
    holdCycles(3);
    applyStimulus(1'b1, 16'h1234, 1'b0);
    checkOutput("pushLatency", bus.fifo_count, 1);
    applyStimulus(1'b1, 16'h1234, 1'b0);
    checkOutput("startLatency", bus.tx, 1'b0);
    holdCycles(Frame + 5);
    checkOutput("singleIdle", bus.busy, 1'b0);

    // Static input
    holdCycles(500);
    checkOutput("staticTx", bus.tx, 1'b1);
    checkOutput("staticCount", bus.fifo_count, 0);

    // Burst and overflow
    for (int v = 1; v <= 6; v++) applyStimulus(1'b1, 16'(v), 1'b0);
    checkOutput("burstOverflow", bus.overflow, 1'b1);
    checkOutput("burstCount", bus.fifo_count, 4);
    holdCycles(5 * Frame + 20);
    applyStimulus(1'b1, bus.debug_in, 1'b1);
    checkOutput("clrOverflow", bus.overflow, 1'b0);

    // Enable gating
    repeat (10) applyStimulus(1'b0, 16'hBEEF, 1'b0);
    checkOutput("gatedCount", bus.fifo_count, 0);
    applyStimulus(1'b1, 16'hBEEF, 1'b0);
    checkOutput("ungatedCount", bus.fifo_count, 1);
    holdCycles(Frame + 5);

    // Reset mid-frame (during byte1), then release synchronisation
    applyStimulus(1'b1, 16'h5555, 1'b0);
    holdCycles(12 * Cpb);
    applyReset();
    applyStimulus(1'b1, 16'h5555, 1'b0);
    checkOutput("releaseEdge1", bus.fifo_count, 0);
    applyStimulus(1'b1, 16'h5555, 1'b0);
    checkOutput("releaseEdge2", bus.fifo_count, 1);
    holdCycles(Frame + 5);

    // Push and pop on the same edge while full and idle
    applyStimulus(1'b1, 16'h1001, 1'b0);
    for (int v = 2; v <= 5; v++) applyStimulus(1'b1, 16'h1000 + 16'(v), 1'b0);
    holdCycles(117);
    checkOutput("fullBeforePush", bus.fifo_count, 4);
    applyStimulus(1'b1, 16'h1006, 1'b0);
    checkOutput("fullPushPopCount", bus.fifo_count, 4);
    checkOutput("fullPushPopOverflow", bus.overflow, 1'b0);
    holdCycles(5 * Frame + 20);

    // Random activity
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      d = bus.debug_in;
      if ($urandom_range(99) < 4) d = 16'($urandom);
      applyStimulus($urandom_range(7) != 0, d, $urandom_range(49) == 0);
    end
    holdCycles(6 * Frame);
    checkOutput("drainedBusy", bus.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
